// File: rtl/cordic_reg_bank.sv
// cordic_reg_bank: host-visible register bank sitting between a simple
// strobe bus and a CORDIC controller. It holds the control word, the three
// operand registers, the captured results and the interrupt status.
//
// Optional feature: define CORDIC_DONE_COUNT_EN to add a 16-bit saturating
// completion counter in IRQ_STAT[31:16]. Without it those bits read 0.
//
// Bus handshake: there is no backpressure. wr_en is a one-cycle strobe that
// takes effect on the edge where it is sampled high. rd_en is a one-cycle
// strobe; rdata is loaded and rvalid is high for exactly the one cycle that
// follows the sampling edge. A read and a write to the same address on the
// same edge return the value held before that write.
module cordic_reg_bank (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic [31:0] ctrl_to_cordic,
    output logic [31:0] x_to_cordic,
    output logic [31:0] y_to_cordic,
    output logic [31:0] z_to_cordic,
    input  logic [31:0] ctrl_from_cordic,
    input  logic        ctrl_wr_en,
    input  logic [31:0] x_res,
    input  logic [31:0] y_res,
    input  logic [31:0] z_res,
    input  logic        irq_in,
    output logic        irq
);

    localparam logic [2:0]  ADDR_CTRL     = 3'd0;
    localparam logic [2:0]  ADDR_X_IN     = 3'd1;
    localparam logic [2:0]  ADDR_Y_IN     = 3'd2;
    localparam logic [2:0]  ADDR_Z_IN     = 3'd3;
    localparam logic [2:0]  ADDR_X_RES    = 3'd4;
    localparam logic [2:0]  ADDR_Y_RES    = 3'd5;
    localparam logic [2:0]  ADDR_Z_RES    = 3'd6;
    localparam logic [2:0]  ADDR_IRQ_STAT = 3'd7;

    localparam logic [31:0] CTRL_RESET    = 32'h0001_1FF0;

    // Storage
    logic [31:0] ctrlReg;
    logic [31:0] xIn;
    logic [31:0] yIn;
    logic [31:0] zIn;
    logic [31:0] xResReg;
    logic [31:0] yResReg;
    logic [31:0] zResReg;
    logic        irqPending;
    logic        irqEnable;
    logic        irqInDly;

    // Decode and next-state helpers
    logic        ctrlWrHit;
    logic        xWrHit;
    logic        yWrHit;
    logic        zWrHit;
    logic        statWrHit;
    logic        completion;
    logic        irqRise;
    logic [31:0] ctrlNext;
    logic        pendingNext;
    logic [15:0] countField;
    logic [31:0] irqStatWord;
    logic [31:0] readMux;

    // The controller's low control bits carry nothing this bank stores.
    logic        unusedCtrlLow;
    assign unusedCtrlLow = ^ctrl_from_cordic[15:0];

    assign ctrlWrHit  = wr_en && (addr == ADDR_CTRL);
    assign xWrHit     = wr_en && (addr == ADDR_X_IN);
    assign yWrHit     = wr_en && (addr == ADDR_Y_IN);
    assign zWrHit     = wr_en && (addr == ADDR_Z_IN);
    assign statWrHit  = wr_en && (addr == ADDR_IRQ_STAT);

    // A writeback while start is already clear is the end of a computation.
    assign completion = ctrl_wr_en && !ctrlReg[0];

    // Rising edge of the controller interrupt against its one-cycle delay.
    assign irqRise    = irq_in && !irqInDly;

    // Operand and control registers feed the controller directly.
    assign ctrl_to_cordic = ctrlReg;
    assign x_to_cordic    = xIn;
    assign y_to_cordic    = yIn;
    assign z_to_cordic    = zIn;

    // Control word: controller owns the upper half and clears start/stop on
    // writeback; a host write to the lower half on the same edge overrides.
    always_comb begin
        ctrlNext = ctrlReg;
        if (ctrl_wr_en) begin
            ctrlNext[31:16] = ctrl_from_cordic[31:16];
            ctrlNext[1:0]   = 2'b00;
        end
        if (ctrlWrHit) begin
            ctrlNext[15:0] = wdata[15:0];
        end
    end

    // Pending flag: write-1-to-clear, with a new interrupt edge taking priority.
    always_comb begin
        pendingNext = irqPending;
        if (statWrHit && wdata[0]) begin
            pendingNext = 1'b0;
        end
        if (irqRise) begin
            pendingNext = 1'b1;
        end
    end

`ifdef CORDIC_DONE_COUNT_EN
    logic [15:0] doneCount;

    // Completion counter: saturates, and a status write with bit 31 set clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            doneCount <= 16'h0000;
        end else if (statWrHit && wdata[31]) begin
            doneCount <= 16'h0000;
        end else if (completion && (doneCount != 16'hFFFF)) begin
            doneCount <= doneCount + 16'h0001;
        end
    end

    assign countField = doneCount;
`else
    assign countField = 16'h0000;
`endif

    assign irqStatWord = {countField, 14'b0, irqEnable, irqPending};

    // Read multiplexer over the pre-edge register contents.
    always_comb begin
        readMux = 32'h0000_0000;
        case (addr)
            ADDR_CTRL:     readMux = ctrlReg;
            ADDR_X_IN:     readMux = xIn;
            ADDR_Y_IN:     readMux = yIn;
            ADDR_Z_IN:     readMux = zIn;
            ADDR_X_RES:    readMux = xResReg;
            ADDR_Y_RES:    readMux = yResReg;
            ADDR_Z_RES:    readMux = zResReg;
            ADDR_IRQ_STAT: readMux = irqStatWord;
            default:       readMux = 32'h0000_0000;
        endcase
    end

    // Control register update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrlReg <= CTRL_RESET;
        end else begin
            ctrlReg <= ctrlNext;
        end
    end

    // Host-written operand registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xIn <= 32'h0000_0000;
            yIn <= 32'h0000_0000;
            zIn <= 32'h0000_0000;
        end else begin
            if (xWrHit) xIn <= wdata;
            if (yWrHit) yIn <= wdata;
            if (zWrHit) zIn <= wdata;
        end
    end

    // Result registers capture only on a completion writeback; host writes ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xResReg <= 32'h0000_0000;
            yResReg <= 32'h0000_0000;
            zResReg <= 32'h0000_0000;
        end else if (completion) begin
            xResReg <= x_res;
            yResReg <= y_res;
            zResReg <= z_res;
        end
    end

    // Interrupt status, input delay and the registered host interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irqPending <= 1'b0;
            irqEnable  <= 1'b0;
            irqInDly   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            irqPending <= pendingNext;
            irqInDly   <= irq_in;
            irq        <= irqPending && irqEnable;
            if (statWrHit) begin
                irqEnable <= wdata[1];
            end
        end
    end

    // Registered read port: data and a one-cycle valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= 32'h0000_0000;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= readMux;
            end
        end
    end

endmodule
